// File: rtl/barrel_shift_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_arb_pkg
// Description : Shared types for the barrel-shift arbiter. Holds the response
//               register state encoding and the packed request record
//               (data, amount, dir) sized by the package default width.
// Revision    : 1.0 - initial release
// ============================================================================
package barrel_shift_arb_pkg;

  localparam int C_SHIFT_REQ_N  = 8;
  localparam int C_SHIFT_REQ_AW = $clog2(C_SHIFT_REQ_N);

  typedef enum logic {ST_EMPTY, ST_FULL} arb_state_t;

  typedef struct packed {
    logic [C_SHIFT_REQ_N-1:0]  data;
    logic [C_SHIFT_REQ_AW-1:0] amount;
    logic                      dir;
  } shift_req_t;

endpackage
`default_nettype wire

// File: rtl/parameterized_barrel_shifter.sv
`default_nettype none
// ============================================================================
// Module      : parameterized_barrel_shifter
// Description : Combinational logarithmic rotator. dir=0 rotates right,
//               dir=1 rotates left, by amount (0..N-1) positions.
// Ports       : data   [N]          operand
//               amount [$clog2(N)]  rotate distance
//               dir    1            0 = right, 1 = left
//               result [N]          rotated operand
// Revision    : 1.0 - initial release
// ============================================================================
module parameterized_barrel_shifter #(
  parameter int N = 8
) (
  input  logic [N-1:0]         data,
  input  logic [$clog2(N)-1:0] amount,
  input  logic                 dir,
  output logic [N-1:0]         result
);

  localparam int C_LOG_N = $clog2(N);

  logic [N-1:0] w_stage [0:C_LOG_N];

  assign w_stage[0] = data;

  // Stage s rotates by 2**s when amount bit s is set.
  for (genvar s = 0; s < C_LOG_N; s++) begin : g_stage
    localparam int C_SH = 1 << s;
    logic [N-1:0] w_rot_r;
    logic [N-1:0] w_rot_l;
    assign w_rot_r = {w_stage[s][C_SH-1:0], w_stage[s][N-1:C_SH]};
    assign w_rot_l = {w_stage[s][N-C_SH-1:0], w_stage[s][N-1:N-C_SH]};
    assign w_stage[s+1] = amount[s] ? (dir ? w_rot_l : w_rot_r) : w_stage[s];
  end

  assign result = w_stage[C_LOG_N];

endmodule
`default_nettype wire

// File: rtl/barrel_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : barrel_shift_arbiter
// Description : Shares one barrel shifter between NUM_REQ requesters. A
//               round-robin arbiter picks one valid request per cycle when
//               the single-entry response register can take it; the result
//               is registered and tagged with the requester index.
// Ports       : clk, rst (sync, active high)
//               req_valid_i/req_ready_o [NUM_REQ]  request handshake
//               req_data_i [NUM_REQ][N], req_amount_i [NUM_REQ][$clog2(N)],
//               req_dir_i [NUM_REQ]                 request operands
//               rsp_valid_o/rsp_ready_i             response handshake
//               rsp_data_o [N], rsp_id_o [ID_W]     response payload
// Config      : BARREL_SHIFT_ARB_FIXED_PRIO_EN - lowest index always wins,
//               no round-robin pointer is built.
// Revision    : 1.0 - initial release
// ============================================================================
module barrel_shift_arbiter
  import barrel_shift_arb_pkg::*;
#(
  parameter  int N       = 8,
  parameter  int NUM_REQ = 2,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int AMT_W   = $clog2(N)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ-1:0][N-1:0]      req_data_i,
  input  logic [NUM_REQ-1:0][AMT_W-1:0]  req_amount_i,
  input  logic [NUM_REQ-1:0]             req_dir_i,
  output logic                           rsp_valid_o,
  input  logic                           rsp_ready_i,
  output logic [N-1:0]                   rsp_data_o,
  output logic [ID_W-1:0]                rsp_id_o
);

  arb_state_t      r_state;
  arb_state_t      w_state_nxt;
  logic            w_can_accept;
  logic            w_found;
  logic            w_accept;
  logic [ID_W-1:0] w_winner;
  logic [N-1:0]    w_shift_res;
  logic [N-1:0]    r_rsp_data;
  logic [ID_W-1:0] r_rsp_id;

`ifdef BARREL_SHIFT_ARB_FIXED_PRIO_EN
  // Scan downward so the lowest asserted index is the last one written.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(i);
      end
    end
  end
`else
  localparam logic [ID_W-1:0] C_LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]   C_NUM_REQ = (ID_W + 1)'(NUM_REQ);

  logic [ID_W-1:0]       r_rr_ptr;
  logic [2*NUM_REQ-1:0]  w_valid_dbl;
  logic [NUM_REQ-1:0]    w_valid_rot;
  logic [ID_W-1:0]       w_offset;
  logic [ID_W:0]         w_sum;

  // Rotate the request vector so bit 0 is the requester at rr_ptr; the
  // first set bit then gives the distance from the pointer to the winner.
  assign w_valid_dbl = {req_valid_i, req_valid_i} >> r_rr_ptr;
  assign w_valid_rot = w_valid_dbl[NUM_REQ-1:0];

  always_comb begin
    w_found  = 1'b0;
    w_offset = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_valid_rot[k]) begin
        w_found  = 1'b1;
        w_offset = ID_W'(k);
      end
    end
  end

  // Pointer + offset modulo NUM_REQ (NUM_REQ need not be a power of two).
  assign w_sum    = {1'b0, r_rr_ptr} + {1'b0, w_offset};
  assign w_winner = (w_sum >= C_NUM_REQ) ? ID_W'(w_sum - C_NUM_REQ) : w_sum[ID_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_winner == C_LAST_ID) ? '0 : w_winner + 1'b1;
    end
  end
`endif

  assign w_can_accept = (r_state == ST_EMPTY) || rsp_ready_i;
  assign w_accept     = w_found && w_can_accept && !rst;

  always_comb begin
    req_ready_o = '0;
    if (w_accept) begin
      req_ready_o[w_winner] = 1'b1;
    end
  end

  parameterized_barrel_shifter #(.N(N)) u_shifter (
    .data   (req_data_i[w_winner]),
    .amount (req_amount_i[w_winner]),
    .dir    (req_dir_i[w_winner]),
    .result (w_shift_res)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An accept always refills the register, even while it is being drained.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_nxt = ST_FULL;
      ST_FULL: begin
        if (w_accept) begin
          w_state_nxt = ST_FULL;
        end else if (rsp_ready_i) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_data <= '0;
      r_rsp_id   <= '0;
    end else if (w_accept) begin
      r_rsp_data <= w_shift_res;
      r_rsp_id   <= w_winner;
    end
  end

  assign rsp_valid_o = (r_state == ST_FULL);
  assign rsp_data_o  = r_rsp_data;
  assign rsp_id_o    = r_rsp_id;

endmodule
`default_nettype wire

// File: tb/tb_barrel_shift_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_barrel_shift_arbiter
// Description : Scoreboard bench for barrel_shift_arbiter (N=8, NUM_REQ=3).
//               A driver applies stimulus on the falling edge and predicts
//               grants from the arbitration rules; predicted results go into
//               a queue that a separate monitor compares against the
//               response port after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_barrel_shift_arbiter;

  localparam int N  = 8;
  localparam int NR = 3;
  localparam int AW = 3;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst        = 1'b1;
  logic [NR-1:0]          req_valid  = '0;
  logic [NR-1:0]          req_ready;
  logic [NR-1:0][N-1:0]   req_data   = '0;
  logic [NR-1:0][AW-1:0]  req_amount = '0;
  logic [NR-1:0]          req_dir    = '0;
  logic                   rsp_valid;
  logic                   rsp_ready  = 1'b0;
  logic [N-1:0]           rsp_data;
  logic [IW-1:0]          rsp_id;

  logic [NR-1:0][N-1:0]   st_data = '0;
  logic [NR-1:0][AW-1:0]  st_amt  = '0;
  logic [NR-1:0]          st_dir  = '0;

  barrel_shift_arbiter #(.N(N), .NUM_REQ(NR)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_data_i   (req_data),
    .req_amount_i (req_amount),
    .req_dir_i    (req_dir),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_id_o     (rsp_id)
  );

  typedef struct {
    logic [N-1:0] data;
    int           id;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   ptr   = 0;
  bit   held  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Rotation as arithmetic on the operand concatenated with itself.
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int a, input logic dir);
    logic [2*N-1:0] dd;
    dd = {d, d};
    if (!dir) begin
      dd = dd >> a;
      return dd[N-1:0];
    end
    dd = dd << a;
    return dd[2*N-1:N];
  endfunction

  // Predict what happens at the coming rising edge from the current inputs.
  task automatic model_edge();
    logic [NR-1:0] exp_ready;
    int            win;
    bit            can;
    exp_t          e;
    exp_ready = '0;
    if (rst) begin
      check("ready_in_reset", 32'(req_ready), 32'(exp_ready));
      sb.delete();
      ptr = 0;
      return;
    end
    can = (sb.size() == 0) || rsp_ready;
    win = -1;
`ifdef BARREL_SHIFT_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NR; i++)
      if (win < 0 && req_valid[i]) win = i;
`else
    for (int k = 0; k < NR; k++)
      if (win < 0 && req_valid[(ptr + k) % NR]) win = (ptr + k) % NR;
`endif
    if (win >= 0 && can) exp_ready[win] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (win >= 0 && can) begin
      e.data = ref_shift(req_data[win], int'(req_amount[win]), req_dir[win]);
      e.id   = win;
      sb.push_back(e);
      ptr = (win + 1) % NR;
    end
  endtask

  task automatic step(input logic [NR-1:0] v, input logic rr, input logic rs, input bit rnd);
    @(negedge clk);
    if (rnd) begin
      for (int r = 0; r < NR; r++) begin
        st_data[r] = N'($urandom);
        st_amt[r]  = AW'($urandom);
        st_dir[r]  = 1'($urandom);
      end
    end
    rst        = rs;
    req_valid  = v;
    rsp_ready  = rr;
    req_data   = st_data;
    req_amount = st_amt;
    req_dir    = st_dir;
    #1;
    model_edge();
  endtask

  // Monitor: retire the entry consumed at this edge, then check what is held.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (held && rsp_ready && sb.size() > 0) void'(sb.pop_front());
      held = (sb.size() > 0);
      check("rsp_valid", 32'(rsp_valid), 32'(held));
      if (held) begin
        check("rsp_data", 32'(rsp_data), 32'(sb[0].data));
        check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
      end
    end
  end

  initial begin
    // Reset held with every requester valid.
    for (int i = 0; i < 3; i++) step(3'b111, 1'b1, 1'b1, 1'b1);
    check("reset_data", 32'(rsp_data), 32'h0);
    check("reset_id", 32'(rsp_id), 32'h0);

    // First grant after reset goes to r0; then r0/r1 alternate.
    for (int i = 0; i < 6; i++) step(3'b011, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(3'b000, 1'b1, 1'b0, 1'b1);

    // Single requester r1: 11110000 rotated right by 4.
    st_data[1] = 8'hF0; st_amt[1] = 3'd4; st_dir[1] = 1'b0;
    step(3'b010, 1'b1, 1'b0, 1'b0);
    step(3'b000, 1'b1, 1'b0, 1'b0);
    check("single_valid", 32'(rsp_valid), 32'h1);
    check("single_data", 32'(rsp_data), 32'h0F);
    check("single_id", 32'(rsp_id), 32'h1);

    // Back-pressure for 5 cycles, then drain and refill in one cycle.
    step(3'b111, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(3'b111, 1'b0, 1'b0, 1'b1);
    step(3'b111, 1'b1, 1'b0, 1'b1);
    step(3'b111, 1'b1, 1'b0, 1'b1);
    step(3'b000, 1'b1, 1'b0, 1'b1);

    // Amount sweep on r0, both directions.
    for (int a = 0; a < N; a++) begin
      for (int d = 0; d < 2; d++) begin
        st_data[0] = 8'hF0; st_amt[0] = AW'(a); st_dir[0] = 1'(d);
        step(3'b001, 1'b1, 1'b0, 1'b0);
        step(3'b000, 1'b1, 1'b0, 1'b0);
        if (a == 0) check("amt0_data", 32'(rsp_data), 32'hF0);
      end
    end

    // Reset while FULL and stalled: nothing stale may reappear.
    step(3'b101, 1'b1, 1'b0, 1'b1);
    step(3'b101, 1'b0, 1'b0, 1'b1);
    step(3'b101, 1'b0, 1'b1, 1'b1);
    step(3'b000, 1'b1, 1'b0, 1'b1);
    step(3'b000, 1'b1, 1'b0, 1'b1);

    // Random traffic with random back-pressure and rare resets.
    for (int i = 0; i < 400; i++) begin
      step(NR'($urandom), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 99) == 0), 1'b1);
    end

    for (int i = 0; i < 3; i++) step(3'b000, 1'b1, 1'b0, 1'b1);
    check("drained", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/barrel_shift_arbiter.md
# barrel_shift_arbiter

Shares one combinational `parameterized_barrel_shifter` instance between NUM_REQ requesters. Each requester presents a shift operation over a valid/ready handshake. Grants are round-robin. Results leave through a single registered, back-pressurable response port tagged with the requester ID. It sits between client blocks and the shifter datapath, so the datapath is never duplicated per client.

## Interface
- `N`, 8: data width; power of two, ≥ 2.
- `NUM_REQ`, 2: number of requesters; 2..8.
- `ID_W`, `$clog2(NUM_REQ)`: localparam; width of requester ID.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid_i`  in  [NUM_REQ]  requester r has an operation pending.
- `req_ready_o`  out  [NUM_REQ]  one-hot or zero; the operation of requester r is accepted this cycle.
- `req_data_i`  in  [NUM_REQ][N]  operand.
- `req_amount_i`  in  [NUM_REQ][$clog2(N)]  shift amount, 0..N-1.
- `req_dir_i`  in  [NUM_REQ]  direction bit; passed unchanged to the shifter.
- `rsp_valid_o`  out  1  result register holds a result.
- `rsp_ready_i`  in  1  consumer takes the result this cycle.
- `rsp_data_o`  out  [N]  shifted result.
- `rsp_id_o`  out  [ID_W]  index of the requester that produced the result.

## Operation
- State machine with two states:
  - EMPTY: `rsp_valid_o`=0.
  - FULL: `rsp_valid_o`=1.
- `can_accept` = EMPTY, or (FULL and `rsp_ready_i`).
- Arbitration:
  - Pointer `rr_ptr` [ID_W].
  - The winner is the first asserted `req_valid_i` scanning from `rr_ptr` upward with wrap at NUM_REQ-1 → 0.
  - `req_ready_o[winner]` = `can_accept`; all other ready bits are 0.
- Ready depends combinationally on `req_valid_i`. Requesters must not make valid depend on ready.
- Accept (winner exists and `can_accept`):
  - Shifter driven from the winner's data/amount/dir.
  - Its output is registered into `rsp_data_o`, and `rsp_id_o` ← winner.
  - State → FULL.
  - `rr_ptr` ← winner+1 mod NUM_REQ.
- FULL with `rsp_ready_i`=1 and no accept: state → EMPTY. `rsp_data_o` and `rsp_id_o` hold their last value.
- FULL with `rsp_ready_i`=0: `rsp_data_o` and `rsp_id_o` stay stable; no `req_ready_o` is asserted.
- No request pending: `rr_ptr` is unchanged.
- A requester that drops valid before it is granted is simply skipped. No operation is ever lost once it has been accepted.
- Amount is never saturated or checked. The full `$clog2(N)` range is legal.

## Timing
- Latency: accept on edge t → `rsp_valid_o`=1 from t+1.
- Throughput: one result per cycle while `rsp_ready_i`=1, including accept-and-drain in the same cycle.
- Reset values:
  - `rsp_valid_o`=0, `rsp_data_o`=0, `rsp_id_o`=0.
  - `rr_ptr`=0, state EMPTY.
  - `req_ready_o`=0 while `rst`=1.
- Reset asserted while FULL: the held result is discarded. `rsp_valid_o`=0 on the cycle after the reset edge.
- Fairness: with all requesters continuously valid and `rsp_ready_i`=1, grants cycle 0,1,…,NUM_REQ-1,0.

## Configuration
- `BARREL_SHIFT_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority, lowest index wins, and `rr_ptr` is not implemented.
  - Undefined (default): round-robin as above.
- Handshake, latency and reset behaviour are identical in both modes.

## Structure
- Package `barrel_shift_arb_pkg` holds:
  - `typedef enum logic {ST_EMPTY, ST_FULL} arb_state_t`.
  - A `shift_req_t` packed struct {data, amount, dir}, parameterised via `N` through a package localparam default.
- Sub-modules:
  - One instance of `parameterized_barrel_shifter #(.N(N))` as the datapath.
  - Arbitration logic is inline. A separate `rr_arbiter` module is not warranted at this size.

## Test plan
- Reset check: hold `rst` 3 cycles with all requests valid → all `req_ready_o`=0, `rsp_valid_o`=0. After release, the first grant goes to r0.
- Single requester: r1 sends data 8'b11110000, amount 4, dir 0 → next cycle `rsp_valid_o`=1, `rsp_data_o`=8'b00001111, `rsp_id_o`=1.
- Round-robin: r0 and r1 continuously valid, `rsp_ready_i`=1 → `rsp_id_o` sequence 0,1,0,1 on consecutive cycles. With the fixed-priority macro defined → 0,0,0,0.
- Back-pressure: FULL with `rsp_ready_i`=0 for 5 cycles → `rsp_data_o` and `rsp_id_o` stable, `req_ready_o`=0. Raising ready gives a drain and a new accept in the same cycle.
- Amount 0 sweep: data 8'b11110000, amount 0, both dir values → result 8'b11110000. Amounts 1..7 match the shifter reference model.
- Mid-operation reset: `rst` pulsed while FULL and ready=0 → `rsp_valid_o`=0 the next cycle, and no stale result appears afterwards.
